alu_execute_stage: RTL

// - Execute stage downstream of the ALU-operation mux: consumes the 4-bit ARM data-processing opcode it selects
//   (IR / control-store / U-bit ADD-SUB), operands from the register-read and shifter stages, and produces a

---
 rtl/arm_pkg.sv | 44 ++++
 rtl/alu_seq_multiplier.sv | 77 +++++++
 rtl/alu_execute_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared ARM execute-stage definitions: data-processing opcodes, NZCV bit
// positions, execute FSM encoding and small opcode-class helpers.
package arm_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

  // Logical ops take C from the shifter and leave V alone
  function automatic logic is_logical_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_EOR) || (op == OP_TST) || (op == OP_TEQ) ||
           (op == OP_ORR) || (op == OP_MOV) || (op == OP_BIC) || (op == OP_MVN);
  endfunction

  // Compare/test ops only set flags and never write a register
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH
// iterations, accumulator preloaded with the MLA addend. Only the low WIDTH
// bits of the product are kept.
module alu_seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] acc_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Partial-product adder; product is the accumulator after this cycle's step
  always_comb begin
    product = acc_q + (mplier_q[0] ? mcand_q : '0);
    done    = busy_q && (cnt_q == CntW'(WIDTH - 1));
    busy    = busy_q;
  end

  // Load on start, step while busy, drop out on flush or final iteration
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (done) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      mcand_d  = multiplicand;
      mplier_d = multiplier;
      acc_d    = acc_init;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end
  end

  // Multiplier state registers; reset discards any partial product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_execute_stage.sv
// ARM execute stage: single-cycle data-processing ALU with NZCV update, plus
// an iterative MUL/MLA that holds off new operations while it runs.
module alu_execute_stage
  import arm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             shift_carry,
  input  logic             set_flags,
  input  logic             mul_en,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             flush,
  input  logic             flags_load,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_wr,
  output logic [3:0]       flags
);

  state_e state_q, state_d;

  logic accept, dp_accept, mul_accept, mul_finish;

  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;
  logic             mul_set_flags_q, mul_set_flags_d;

  logic [WIDTH-1:0] add_x, add_y, logic_res, alu_res;
  logic             add_cin, add_ovf;
  logic [WIDTH:0]   add_sum;
  logic [3:0]       alu_flags;

  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             result_wr_q, result_wr_d;
  logic [3:0]       flags_q, flags_d;

  alu_seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_accept),
    .flush        (flush),
    .multiplicand (op_a),
    .multiplier   (op_b),
    .acc_init     (acc_en ? acc_in : '0),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: multiply occupies the stage until done or flushed
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && mul_en) begin
          state_d = ST_MUL_RUN;
        end
      end
      ST_MUL_RUN: begin
        if (flush || mul_done || !mul_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake and accept qualification (flush suppresses accept)
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    accept     = in_valid && in_ready && !flush;
    dp_accept  = accept && !mul_en;
    mul_accept = accept && mul_en;
    mul_finish = (state_q == ST_MUL_RUN) && mul_done && !flush;
  end

  // Data-processing ALU: one WIDTH+1 adder serves every arithmetic opcode
  always_comb begin
    add_x     = op_a;
    add_y     = op_b;
    add_cin   = 1'b0;
    logic_res = '0;
    alu_flags = '0;
    case (alu_operation)
      OP_SUB, OP_CMP: begin
        add_y   = ~op_b;
        add_cin = 1'b1;
      end
      OP_RSB: begin
        add_x   = op_b;
        add_y   = ~op_a;
        add_cin = 1'b1;
      end
      OP_ADC: add_cin = flags_q[FLAG_C];
      OP_SBC: begin
        add_y   = ~op_b;
        add_cin = flags_q[FLAG_C];
      end
      OP_RSC: begin
        add_x   = op_b;
        add_y   = ~op_a;
        add_cin = flags_q[FLAG_C];
      end
      default: ;
    endcase
    case (alu_operation)
      OP_AND, OP_TST: logic_res = op_a & op_b;
      OP_EOR, OP_TEQ: logic_res = op_a ^ op_b;
      OP_ORR:         logic_res = op_a | op_b;
      OP_MOV:         logic_res = op_b;
      OP_BIC:         logic_res = op_a & ~op_b;
      OP_MVN:         logic_res = ~op_b;
      default:        logic_res = '0;
    endcase
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    // Overflow when like-signed operands give a result of the other sign
    add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);
    alu_res = is_logical_op(alu_operation) ? logic_res : add_sum[WIDTH-1:0];
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    if (is_logical_op(alu_operation)) begin
      alu_flags[FLAG_C] = shift_carry;
      alu_flags[FLAG_V] = flags_q[FLAG_V];
    end else begin
      alu_flags[FLAG_C] = add_sum[WIDTH];
      alu_flags[FLAG_V] = add_ovf;
    end
  end

  // Result / flag next state; a direct flag load overrides any ALU update
  always_comb begin
    result_d        = result_q;
    out_valid_d     = 1'b0;
    result_wr_d     = 1'b0;
    flags_d         = flags_q;
    mul_set_flags_d = mul_set_flags_q;
    if (mul_accept) begin
      mul_set_flags_d = set_flags;
    end
    if (dp_accept) begin
      result_d    = alu_res;
      out_valid_d = 1'b1;
      result_wr_d = !is_test_op(alu_operation);
      if (set_flags) begin
        flags_d = alu_flags;
      end
    end
    if (mul_finish) begin
      result_d    = mul_product;
      out_valid_d = 1'b1;
      result_wr_d = 1'b1;
      if (mul_set_flags_q) begin
        flags_d[FLAG_N] = mul_product[WIDTH-1];
        flags_d[FLAG_Z] = (mul_product == '0);
      end
    end
    if (flags_load) begin
      flags_d = flags_in;
    end
  end

  // Output and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q        <= '0;
      out_valid_q     <= 1'b0;
      result_wr_q     <= 1'b0;
      flags_q         <= 4'b0000;
      mul_set_flags_q <= 1'b0;
    end else begin
      result_q        <= result_d;
      out_valid_q     <= out_valid_d;
      result_wr_q     <= result_wr_d;
      flags_q         <= flags_d;
      mul_set_flags_q <= mul_set_flags_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign result_wr = result_wr_q;
  assign flags     = flags_q;

endmodule
